// File: rtl/mdu_if.sv
// mdu_if: operand, opcode and result bundle between the EX stage and the
// multiply/divide unit. The opcode field widens to 4 bits when MDU_MADD_EN
// is defined so the multiply-accumulate opcodes fit.
interface mdu_if;
`ifdef MDU_MADD_EN
   logic [3:0]  MDOp;
`else
   logic [2:0]  MDOp;
`endif
   logic [31:0] A;
   logic [31:0] B;
   logic        Start;
   logic        Flush;
   logic        Busy;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (
      output A, B, MDOp, Start, Flush,
      input  Busy, HI, LO
   );

   modport slave (
      input  A, B, MDOp, Start, Flush,
      output Busy, HI, LO
   );
endinterface

// File: rtl/mdu.sv
// mdu: EX-stage multiply/divide unit holding the architectural HI/LO pair.
// mult/multu/div/divu compute the full 64-bit result at the Start edge and
// park it in internal registers; HI/LO are updated only after the fixed
// latency has elapsed, so younger md-class instructions stalled on Busy see
// a consistent HI/LO. mthi/mtlo write directly when idle.
// Optional feature macro: MDU_MADD_EN (madd/maddu/msub/msubu, 4-bit MDOp).
module mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic clk,
   input  logic Reset,
   mdu_if.slave bus
);

`ifdef MDU_MADD_EN
   localparam int OPW = 4;
`else
   localparam int OPW = 3;
`endif

   localparam logic [OPW-1:0] OP_MULT  = OPW'(1);
   localparam logic [OPW-1:0] OP_MULTU = OPW'(2);
   localparam logic [OPW-1:0] OP_DIV   = OPW'(3);
   localparam logic [OPW-1:0] OP_DIVU  = OPW'(4);
   localparam logic [OPW-1:0] OP_MTHI  = OPW'(5);
   localparam logic [OPW-1:0] OP_MTLO  = OPW'(6);
`ifdef MDU_MADD_EN
   localparam logic [OPW-1:0] OP_MADD  = OPW'(8);
   localparam logic [OPW-1:0] OP_MADDU = OPW'(9);
   localparam logic [OPW-1:0] OP_MSUB  = OPW'(10);
   localparam logic [OPW-1:0] OP_MSUBU = OPW'(11);
`endif

   // The counter is loaded with N-1 so that Busy stays high for exactly N cycles.
   localparam logic [4:0] MULT_LOAD = 5'(MULT_CYCLES - 1);
   localparam logic [4:0] DIV_LOAD  = 5'(DIV_CYCLES - 1);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t      state;
   logic [4:0]  count;
   logic        busy_q;
   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic [31:0] res_hi;
   logic [31:0] res_lo;

   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] den_u;
   logic [31:0] den_s;
   logic [31:0] quo_u;
   logic [31:0] rem_u;
   logic [31:0] quo_m;
   logic [31:0] rem_m;
   logic [31:0] quo_s;
   logic [31:0] rem_s;
   logic        div_zero;
   logic        is_md_op;
   logic [4:0]  load_val;
   logic [63:0] next_res;

   // Arithmetic datapath: all candidate results for the current operands, and
   // selection of the one that the Start edge will latch.
   always_comb begin
      prod_s   = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
      prod_u   = {32'd0, bus.A} * {32'd0, bus.B};

      // Signed division works on magnitudes so that 0x80000000 / -1 needs no
      // special case: the magnitude quotient 0x80000000 negates to itself.
      a_mag    = bus.A[31] ? (~bus.A + 32'd1) : bus.A;
      b_mag    = bus.B[31] ? (~bus.B + 32'd1) : bus.B;
      div_zero = (bus.B == 32'd0);
      den_u    = div_zero ? 32'd1 : bus.B;
      den_s    = div_zero ? 32'd1 : b_mag;
      quo_u    = bus.A / den_u;
      rem_u    = bus.A % den_u;
      quo_m    = a_mag / den_s;
      rem_m    = a_mag % den_s;
      quo_s    = (bus.A[31] ^ bus.B[31]) ? (~quo_m + 32'd1) : quo_m;
      rem_s    = bus.A[31] ? (~rem_m + 32'd1) : rem_m;

      next_res = 64'd0;
      is_md_op = 1'b0;
      load_val = MULT_LOAD;
      case (bus.MDOp)
         OP_MULT: begin
            next_res = prod_s;
            is_md_op = 1'b1;
         end
         OP_MULTU: begin
            next_res = prod_u;
            is_md_op = 1'b1;
         end
         OP_DIV: begin
            next_res = div_zero ? {bus.A, 32'hFFFF_FFFF} : {rem_s, quo_s};
            is_md_op = 1'b1;
            load_val = DIV_LOAD;
         end
         OP_DIVU: begin
            next_res = div_zero ? {bus.A, 32'hFFFF_FFFF} : {rem_u, quo_u};
            is_md_op = 1'b1;
            load_val = DIV_LOAD;
         end
`ifdef MDU_MADD_EN
         OP_MADD: begin
            next_res = {hi_q, lo_q} + prod_s;
            is_md_op = 1'b1;
         end
         OP_MADDU: begin
            next_res = {hi_q, lo_q} + prod_u;
            is_md_op = 1'b1;
         end
         OP_MSUB: begin
            next_res = {hi_q, lo_q} - prod_s;
            is_md_op = 1'b1;
         end
         OP_MSUBU: begin
            next_res = {hi_q, lo_q} - prod_u;
            is_md_op = 1'b1;
         end
`endif
         default: begin
         end
      endcase
   end

   // Control FSM with registered Busy/HI/LO. A flushed instruction never
   // starts an operation or moves to HI/LO, but a running operation belongs
   // to an older committed instruction and always completes.
   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         state  <= IDLE;
         count  <= 5'd0;
         busy_q <= 1'b0;
         hi_q   <= 32'd0;
         lo_q   <= 32'd0;
         res_hi <= 32'd0;
         res_lo <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.Start && !bus.Flush && is_md_op) begin
                  state  <= RUN;
                  busy_q <= 1'b1;
                  count  <= load_val;
                  res_hi <= next_res[63:32];
                  res_lo <= next_res[31:0];
               end else if (!bus.Flush && bus.MDOp == OP_MTHI) begin
                  hi_q <= bus.A;
               end else if (!bus.Flush && bus.MDOp == OP_MTLO) begin
                  lo_q <= bus.A;
               end
            end
            RUN: begin
               if (count == 5'd0) begin
                  hi_q   <= res_hi;
                  lo_q   <= res_lo;
                  busy_q <= 1'b0;
                  state  <= IDLE;
               end else begin
                  count <= count - 5'd1;
               end
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.Busy = busy_q;
   assign bus.HI   = hi_q;
   assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: self-checking bench for mdu. Directed vector table, hand-written
// multi-cycle corner sequences, and randomized operations checked against a
// 64-bit integer arithmetic reference model. Define MDU_MADD_EN to also
// exercise the accumulate opcodes.
module tb_mdu;

`ifdef MDU_MADD_EN
   localparam int OPW = 4;
`else
   localparam int OPW = 3;
`endif
   localparam int MULT_CYCLES = 5;
   localparam int DIV_CYCLES  = 10;

   localparam logic [3:0] MULT  = 4'd1;
   localparam logic [3:0] MULTU = 4'd2;
   localparam logic [3:0] DIV   = 4'd3;
   localparam logic [3:0] DIVU  = 4'd4;
   localparam logic [3:0] MTHI  = 4'd5;
   localparam logic [3:0] MTLO  = 4'd6;

   typedef struct packed {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] expected;
   } vec_t;

   logic        clk;
   logic        reset_n;
   int          vectors;
   int          miscompares;
   logic [31:0] model_hi;
   logic [31:0] model_lo;
   vec_t        vecs [10];
   logic [3:0]  rand_ops [$];

   mdu_if bus ();

   mdu #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES)
   ) dut (
      .clk   (clk),
      .Reset (reset_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference arithmetic from the instruction definitions using 64-bit integers.
   function automatic logic [63:0] refResult(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] acc);
      longint          sa;
      longint          sb;
      longint unsigned ua;
      longint unsigned ub;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (op)
         4'd1:  return 64'(sa * sb);
         4'd2:  return 64'(ua * ub);
         4'd3:  if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                else return {32'(sa % sb), 32'(sa / sb)};
         4'd4:  if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                else return {32'(ua % ub), 32'(ua / ub)};
         4'd8:  return acc + 64'(sa * sb);
         4'd9:  return acc + 64'(ua * ub);
         4'd10: return acc - 64'(sa * sb);
         4'd11: return acc - 64'(ua * ub);
         default: return acc;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Drive one instruction at the falling edge, let the rising edge take it,
   // then return to a quiet bus 1 time unit after that edge.
   task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic start, input logic flush);
      @(negedge clk);
      bus.MDOp  = OPW'(op);
      bus.A     = a;
      bus.B     = b;
      bus.Start = start;
      bus.Flush = flush;
      @(posedge clk);
      #1;
      bus.MDOp  = '0;
      bus.Start = 1'b0;
      bus.Flush = 1'b0;
   endtask

   task automatic moveTo(input string name, input logic [3:0] op, input logic [31:0] a, input logic flush);
      applyStimulus(op, a, 32'd0, 1'b0, flush);
      if (!flush) begin
         if (op == MTHI) model_hi = a;
         else model_lo = a;
      end
      checkOutput({name, " busy"}, 64'(bus.Busy), 64'd0);
      checkOutput({name, " hilo"}, {bus.HI, bus.LO}, {model_hi, model_lo});
   endtask

   // Issue one multi-cycle op, optionally injecting another bus request at a
   // given Busy cycle, and check latency, HI/LO hold and final result.
   task automatic runOp(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] expected, input int inj_at,
                        input logic [3:0] inj_op, input logic [31:0] inj_a, input logic [31:0] inj_b,
                        input logic inj_start, input logic inj_flush);
      int n;
      int busy_cycles;
      int hold_errs;
      n = (op == DIV || op == DIVU) ? DIV_CYCLES : MULT_CYCLES;
      busy_cycles = 0;
      hold_errs = 0;
      applyStimulus(op, a, b, 1'b1, 1'b0);
      while (bus.Busy === 1'b1 && busy_cycles < 100) begin
         busy_cycles++;
         if ({bus.HI, bus.LO} !== {model_hi, model_lo}) hold_errs++;
         if (busy_cycles == inj_at) begin
            bus.MDOp  = OPW'(inj_op);
            bus.A     = inj_a;
            bus.B     = inj_b;
            bus.Start = inj_start;
            bus.Flush = inj_flush;
         end
         @(posedge clk);
         #1;
         bus.MDOp  = '0;
         bus.Start = 1'b0;
         bus.Flush = 1'b0;
      end
      checkOutput({name, " busy cycles"}, 64'(busy_cycles), 64'(n));
      checkOutput({name, " hilo hold"}, 64'(hold_errs), 64'd0);
      checkOutput({name, " hilo"}, {bus.HI, bus.LO}, expected);
      {model_hi, model_lo} = expected;
   endtask

   initial begin : watchdog
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   initial begin : main
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      vectors = 0;
      miscompares = 0;
      model_hi = 32'd0;
      model_lo = 32'd0;

      vecs[0] = '{MULT,  32'hFFFF_FFFE, 32'd3,         64'hFFFF_FFFF_FFFF_FFFA};
      vecs[1] = '{MULTU, 32'hFFFF_FFFE, 32'd3,         64'h0000_0002_FFFF_FFFA};
      vecs[2] = '{DIV,   32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD};
      vecs[3] = '{DIVU,  32'd7,         32'd0,         64'h0000_0007_FFFF_FFFF};
      vecs[4] = '{DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000};
      vecs[5] = '{DIV,   32'd7,         32'd0,         64'h0000_0007_FFFF_FFFF};
      vecs[6] = '{DIVU,  32'hFFFF_FFFF, 32'd10,        64'h0000_0005_1999_9999};
      vecs[7] = '{MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
      vecs[8] = '{MULT,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
      vecs[9] = '{DIV,   32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD};

      rand_ops = {MULT, MULTU, DIV, DIVU};
`ifdef MDU_MADD_EN
      rand_ops.push_back(4'd8);
      rand_ops.push_back(4'd9);
      rand_ops.push_back(4'd10);
      rand_ops.push_back(4'd11);
`endif

      reset_n   = 1'b0;
      bus.MDOp  = '0;
      bus.A     = 32'd0;
      bus.B     = 32'd0;
      bus.Start = 1'b0;
      bus.Flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset busy", 64'(bus.Busy), 64'd0);
      checkOutput("reset hilo", {bus.HI, bus.LO}, 64'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // Asynchronous reset in the middle of a running mult.
      moveTo("pre-reset mthi", MTHI, 32'hAAAA_5555, 1'b0);
      moveTo("pre-reset mtlo", MTLO, 32'h5555_AAAA, 1'b0);
      applyStimulus(MULT, 32'd3, 32'd4, 1'b1, 1'b0);
      checkOutput("mid-run busy", 64'(bus.Busy), 64'd1);
      @(posedge clk);
      #3;
      reset_n = 1'b0;
      #1;
      checkOutput("async reset busy", 64'(bus.Busy), 64'd0);
      checkOutput("async reset hi", 64'(bus.HI), 64'd0);
      checkOutput("async reset lo", 64'(bus.LO), 64'd0);
      model_hi = 32'd0;
      model_lo = 32'd0;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("post-reset idle busy", 64'(bus.Busy), 64'd0);
      checkOutput("post-reset idle hilo", {bus.HI, bus.LO}, 64'd0);

      // Directed vector table.
      for (int i = 0; i < 10; i++) begin
         runOp($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].expected,
               0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
      end

      // Second Start during Busy is ignored.
      runOp("restart ignored", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000,
            3, MULT, 32'd5, 32'd5, 1'b1, 1'b0);

      // mthi when idle; mtlo while busy has no effect.
      moveTo("mthi idle", MTHI, 32'h1234_5678, 1'b0);
      runOp("mtlo while busy", MULT, 32'h10, 32'h10, 64'h0000_0000_0000_0100,
            2, MTLO, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0);

      // Flushed Start, flushed mthi, reserved op: nothing changes.
      applyStimulus(MULT, 32'd2, 32'd3, 1'b1, 1'b1);
      checkOutput("flushed start busy", 64'(bus.Busy), 64'd0);
      @(posedge clk);
      #1;
      checkOutput("flushed start busy later", 64'(bus.Busy), 64'd0);
      checkOutput("flushed start hilo", {bus.HI, bus.LO}, {model_hi, model_lo});
      moveTo("flushed mthi", MTHI, 32'hCAFE_F00D, 1'b1);
      applyStimulus(4'd7, 32'd9, 32'd9, 1'b1, 1'b0);
      checkOutput("reserved op busy", 64'(bus.Busy), 64'd0);
      checkOutput("reserved op hilo", {bus.HI, bus.LO}, {model_hi, model_lo});

      // Flush during RUN does not cancel the running op.
      runOp("flush during run", MULTU, 32'hFFFF_FFFE, 32'd3, 64'h0000_0002_FFFF_FFFA,
            2, 4'd0, 32'd0, 32'd0, 1'b0, 1'b1);

`ifdef MDU_MADD_EN
      moveTo("madd pre mthi", MTHI, 32'd0, 1'b0);
      moveTo("madd pre mtlo", MTLO, 32'hFFFF_FFFF, 1'b0);
      runOp("maddu carry", 4'd9, 32'd1, 32'd1, 64'h0000_0001_0000_0000,
            0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
`endif

      // Randomized operations against the reference model.
      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 9) < 2) begin
            moveTo($sformatf("rand%0d move", i), ($urandom_range(0, 1) == 0) ? MTHI : MTLO,
                   $urandom, 1'b0);
         end else begin
            op = rand_ops[$urandom_range(0, rand_ops.size() - 1)];
            a  = $urandom;
            case ($urandom_range(0, 3))
               0: b = 32'd0;
               1: b = $urandom_range(1, 9);
               2: begin
                  a = 32'h8000_0000;
                  b = 32'hFFFF_FFFF;
               end
               default: b = $urandom;
            endcase
            runOp($sformatf("rand%0d op%0d", i, op), op, a, b,
                  refResult(op, a, b, {model_hi, model_lo}),
                  0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multiply/divide unit in the EX stage.
- Consumes the forwarded rs/rt operands read from the GRF and holds the architectural HI/LO registers.
- HI/LO return to the GRF write port via mfhi/mflo on the normal EX->MEM->WB path.
- Multi-cycle: the hazard unit stalls any md-class instruction in ID while Start or Busy is high.

Parameters:
- MULT_CYCLES, 5, cycles from Start to HI/LO valid for mult/multu (allowed range 1..31).
- DIV_CYCLES, 10, cycles from Start to HI/LO valid for div/divu (allowed range 1..31).

Ports:
- clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low reset.
- A  input  32  operand from forwarded rs.
- B  input  32  operand from forwarded rt.
- MDOp  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- Start  input  1  one-cycle strobe qualifying MDOp 1..4.
- Flush  input  1  EX-stage instruction cancelled (exception/interrupt); suppresses Start/mthi/mtlo this cycle.
- Busy  output  1  computation in progress.
- HI  output  32  HI register.
- LO  output  32  LO register.

Behaviour:
- Reset (Reset==0, async): state IDLE, Busy=0, HI=0, LO=0, counter=0, internal result regs=0. This holds from any state, mid-operation included.
- States:
  - IDLE: Busy=0.
  - RUN: Busy=1; counter loaded with N-1, where N = MULT_CYCLES or DIV_CYCLES.
- IDLE -> RUN:
  - Condition: posedge with Start=1, Flush=0, MDOp in 1..4.
  - Full 64-bit result is computed from A/B and latched in internal regs at this edge.
  - HI/LO keep their old values while in RUN.
- RUN:
  - Counter decrements each cycle.
  - When counter==0: HI/LO take the internal result at that edge, then go to IDLE.
  - Busy is high for exactly N cycles after the Start edge. HI/LO are new in the first cycle Busy is 0.
- Start while Busy=1: ignored. The hazard unit never does this; the bench checks that it is ignored.
- mult: signed 32x32 -> {HI,LO} 64-bit product. multu: unsigned.
- div (signed):
  - LO = quotient truncated toward zero; HI = remainder with the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- divu: unsigned quotient/remainder.
- Divide by zero (B==0): LO=0xFFFFFFFF, HI=A, with normal latency. Signed and unsigned behave the same.
- mthi/mtlo:
  - Only when Busy=0 and Flush=0: HI (or LO) <= A at the next edge.
  - Busy stays 0. Start is not required for MDOp 5/6.
  - Ignored while Busy=1.
- Flush=1 with Start in IDLE: no transition, HI/LO unchanged.
- Flush while Busy=1: no effect. The operation completes, because it belongs to an older, committed instruction.
- MDOp 0/7, or Start with MDOp 5/6: no state change.

Optional Feature:
- Macro: MDU_MADD_EN.
- When defined:
  - MDOp is 4 bits wide.
  - Added ops: 8 madd, 9 maddu, 10 msub, 11 msubu.
  - These accumulate as {HI,LO} +/- product (64-bit, wrap-around), using the {HI,LO} value sampled at the Start edge.
  - Latency is MULT_CYCLES.
- When undefined:
  - MDOp is 3 bits; only ops 0..7 exist.
  - No accumulate datapath is synthesised.

Test Plan:
1. Reset low mid-RUN (after a mult Start) -> Busy, HI and LO read 0 immediately, without waiting for a clock edge. After release, IDLE.
2. mult A=0xFFFFFFFE (-2), B=3, Start -> Busy=1 for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
3. div A=0xFFFFFFF9 (-7), B=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=0 -> LO=0xFFFFFFFF, HI=7.
4. div A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0. Second Start issued at cycle 3 of Busy -> ignored; result unchanged and Busy duration unchanged.
5. mthi A=0x12345678 with Busy=0 -> HI=0x12345678 the next cycle, Busy stays 0. mtlo issued while Busy -> LO unaffected until the running op writes it.
6. Start+Flush with mult -> Busy stays 0, HI/LO unchanged. Flush during RUN -> op completes normally. With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, maddu A=1, B=1 -> HI=1, LO=0.
